l2_burst_adaptor: RTL and testbench

- Sits directly downstream of the L2 data array and its controller, between the 256-bit L2 line interface and the 64-bit physical-memory burst interface.
- Line fill: collects BEATS memory beats into one 256-bit line for writing into the array.
- Writeback: takes a whole dirty line read out of the array and serialises it into BEATS beats to memory.
- Handles one transaction at a time; any other request is ignored while busy.

---
 rtl/l2_pkg.sv | 9 +
 rtl/line_shift_buf.sv | 34 +++
 rtl/l2_burst_adaptor.sv | 96 +++++++++
 tb/tb_l2_burst_adaptor.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/l2_pkg.sv
// Shared defaults and FSM state encoding for the L2 line <-> memory burst adaptor.
package l2_pkg;
    localparam int LINE_W_DEF  = 256;
    localparam int BURST_W_DEF = 64;
    localparam int ADDR_W_DEF  = 32;
    localparam int OFFSET_W    = $clog2(LINE_W_DEF / 8);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
endpackage

// File: rtl/line_shift_buf.sv
// Line-wide buffer: whole-line load for writeback, per-beat slice fill and drain indexed by beat count.
module line_shift_buf #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64,
    parameter int CNT_W   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [LINE_W-1:0]  load_data,
    input  logic               fill,
    input  logic [CNT_W-1:0]   idx,
    input  logic [BURST_W-1:0] beat_wr,
    output logic [LINE_W-1:0]  line_d,
    output logic [BURST_W-1:0] beat_rd
);
    logic [LINE_W-1:0] line_q;

    // line_d exposes the post-update value so the top can capture a fill including its last beat
    always_comb begin
        line_d = line_q;
        if (load)
            line_d = load_data;
        else if (fill)
            line_d[idx*BURST_W +: BURST_W] = beat_wr;
    end

    assign beat_rd = line_q[idx*BURST_W +: BURST_W];

    always_ff @(posedge clk) begin
        if (!rst_n) line_q <= '0;
        else        line_q <= line_d;
    end
endmodule

// File: rtl/l2_burst_adaptor.sv
// Converts between 256-bit L2 lines and 64-bit memory bursts: line fill (RD) and writeback (WR), one at a time.
module l2_burst_adaptor
    import l2_pkg::*;
#(
    parameter int LINE_W  = LINE_W_DEF,
    parameter int BURST_W = BURST_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               line_read_i,
    input  logic               line_write_i,
    input  logic [ADDR_W-1:0]  line_addr_i,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    output logic               line_resp_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    output logic               mem_read_o,
    output logic               mem_write_o,
    output logic [BURST_W-1:0] mem_burst_o,
    input  logic [BURST_W-1:0] mem_burst_i,
    input  logic               mem_resp_i
);
    localparam int BEATS = LINE_W / BURST_W;
    localparam int CNT_W = $clog2(BEATS);
    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt;
    logic               accept_rd, accept_wr, beat, last;
    logic [LINE_W-1:0]  buf_d;
    logic [BURST_W-1:0] buf_beat;

    // Handshakes only count while a burst is actually in flight
    assign beat = mem_resp_i && (state == RD || state == WR);
    assign last = beat && (cnt == CNT_W'(BEATS - 1));

    always_comb begin
        state_n   = state;
        accept_rd = 1'b0;
        accept_wr = 1'b0;
        case (state)
            IDLE: begin
                if (line_read_i) begin
                    accept_rd = 1'b1;
                    state_n   = RD;
                end else if (line_write_i) begin
                    accept_wr = 1'b1;
                    state_n   = WR;
                end
            end
            RD, WR:  if (last) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            mem_addr_o <= '0;
            line_o     <= '0;
        end else begin
            state <= state_n;
            if (beat)
                cnt <= last ? '0 : cnt + 1'b1;
            if (accept_rd || accept_wr)
                mem_addr_o <= line_addr_i & ~ALIGN_MASK;
            if (last)
                line_o <= buf_d;
        end
    end

    line_shift_buf #(
        .LINE_W  (LINE_W),
        .BURST_W (BURST_W),
        .CNT_W   (CNT_W)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept_wr),
        .load_data (line_i),
        .fill      (beat && state == RD),
        .idx       (cnt),
        .beat_wr   (mem_burst_i),
        .line_d    (buf_d),
        .beat_rd   (buf_beat)
    );

    assign mem_read_o  = (state == RD);
    assign mem_write_o = (state == WR);
    assign line_resp_o = (state == DONE);
    assign mem_burst_o = (state == WR) ? buf_beat : '0;
endmodule

// File: tb/tb_l2_burst_adaptor.sv
module tb_l2_burst_adaptor;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         line_read_i, line_write_i;
  logic [31:0]  line_addr_i;
  logic [255:0] line_i, line_o;
  logic         line_resp_o, mem_read_o, mem_write_o, mem_resp_i;
  logic [31:0]  mem_addr_o;
  logic [63:0]  mem_burst_o, mem_burst_i;

  int vectors = 0;
  int errs    = 0;

  l2_burst_adaptor dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .line_read_i  (line_read_i),
    .line_write_i (line_write_i),
    .line_addr_i  (line_addr_i),
    .line_i       (line_i),
    .line_o       (line_o),
    .line_resp_o  (line_resp_o),
    .mem_addr_o   (mem_addr_o),
    .mem_read_o   (mem_read_o),
    .mem_write_o  (mem_write_o),
    .mem_burst_o  (mem_burst_o),
    .mem_burst_i  (mem_burst_i),
    .mem_resp_i   (mem_resp_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    if (obs !== exp) begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [63:0]  b [4];
  logic [255:0] exp_line;
  logic [6:0]   pat;
  int           n;

  initial begin
    rst_n = 1'b0; line_read_i = 1'b0; line_write_i = 1'b0;
    line_addr_i = '0; line_i = '0; mem_burst_i = '0; mem_resp_i = 1'b0;
    tick(); tick();
    chk("rst_resp",  line_resp_o, 1'b0);
    chk("rst_rd",    mem_read_o,  1'b0);
    chk("rst_wr",    mem_write_o, 1'b0);
    chk("rst_line",  line_o,      256'h0);
    chk("rst_addr",  mem_addr_o,  32'h0);
    chk("rst_burst", mem_burst_o, 64'h0);
    rst_n = 1'b1;
    tick();

    line_read_i = 1'b1; line_addr_i = 32'h0000_1234;
    tick();
    line_read_i = 1'b0;
    chk("fill_rd",   mem_read_o, 1'b1);
    chk("fill_addr", mem_addr_o, 32'h0000_1220);
    mem_resp_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("fill_noresp", line_resp_o, 1'b0);
      mem_burst_i = 64'h1111_1111_1111_1111 * (k + 1);
      tick();
    end
    mem_resp_i = 1'b0;
    chk("fill_resp",   line_resp_o, 1'b1);
    chk("fill_rd_off", mem_read_o,  1'b0);
    chk("fill_line",   line_o, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    tick();
    chk("fill_resp_1cyc", line_resp_o, 1'b0);
    chk("fill_line_hold", line_o[63:0], 64'h1111_1111_1111_1111);

    b[0] = 64'hDEAD_BEEF_0000_0001; b[1] = 64'hCAFE_F00D_0000_0002;
    b[2] = 64'h0123_4567_89AB_CDEF; b[3] = 64'hFEDC_BA98_7654_3210;
    pat = 7'b1001101;
    line_read_i = 1'b1; line_addr_i = 32'h0000_0040;
    tick();
    line_read_i = 1'b0;
    n = 0;
    for (int i = 6; i >= 0; i--) begin
      chk("stall_rd", mem_read_o, 1'b1);
      mem_resp_i  = pat[i];
      mem_burst_i = pat[i] ? b[n] : 64'hBAD0_BAD0_BAD0_BAD0;
      if (pat[i]) n++;
      tick();
    end
    mem_resp_i = 1'b0;
    chk("stall_rd_off", mem_read_o,  1'b0);
    chk("stall_resp",   line_resp_o, 1'b1);
    chk("stall_line",   line_o, {b[3], b[2], b[1], b[0]});
    tick();

    exp_line = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    chk("wb_idle_wr", mem_write_o, 1'b0);
    line_write_i = 1'b1; line_i = exp_line; line_addr_i = 32'hFFFF_FFFF;
    tick();
    line_write_i = 1'b0; line_i = '0;
    chk("wb_addr", mem_addr_o, 32'hFFFF_FFE0);
    mem_resp_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("wb_wr",    mem_write_o, 1'b1);
      chk("wb_burst", mem_burst_o, exp_line[k*64 +: 64]);
      tick();
    end
    mem_resp_i = 1'b0;
    chk("wb_wr_off", mem_write_o, 1'b0);
    chk("wb_resp",   line_resp_o, 1'b1);
    chk("wb_line",   line_o,      exp_line);
    tick();

    line_read_i = 1'b1; line_write_i = 1'b1; line_i = {4{64'h5555_5555_5555_5555}};
    line_addr_i = 32'h0000_0100;
    tick();
    line_read_i = 1'b0; line_write_i = 1'b0;
    mem_resp_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("both_rd", mem_read_o,  1'b1);
      chk("both_wr", mem_write_o, 1'b0);
      mem_burst_i = 64'h0F0F_0000_0000_0000 + 64'(k);
      tick();
    end
    mem_resp_i = 1'b0;
    chk("both_wr_done", mem_write_o, 1'b0);
    chk("both_line",    line_o, {64'h0F0F_0000_0000_0003, 64'h0F0F_0000_0000_0002,
                                 64'h0F0F_0000_0000_0001, 64'h0F0F_0000_0000_0000});
    tick();
    chk("both_idle_wr", mem_write_o, 1'b0);

    line_read_i = 1'b1; line_addr_i = 32'h0000_2000;
    tick();
    line_read_i = 1'b0;
    mem_resp_i = 1'b1;
    mem_burst_i = 64'hAAAA_0000_0000_0001; tick();
    mem_burst_i = 64'hAAAA_0000_0000_0002; tick();
    mem_resp_i = 1'b0; rst_n = 1'b0;
    tick();
    chk("abort_resp",  line_resp_o, 1'b0);
    chk("abort_rd",    mem_read_o,  1'b0);
    chk("abort_wr",    mem_write_o, 1'b0);
    chk("abort_line",  line_o,      256'h0);
    chk("abort_addr",  mem_addr_o,  32'h0);
    chk("abort_burst", mem_burst_o, 64'h0);
    rst_n = 1'b1;
    tick();
    chk("abort_no_resp", line_resp_o, 1'b0);
    line_read_i = 1'b1; line_addr_i = 32'h0000_3000;
    tick();
    line_read_i = 1'b0;
    mem_resp_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("refill_noresp", line_resp_o, 1'b0);
      mem_burst_i = 64'hBBBB_0000_0000_0010 + 64'(k);
      tick();
    end
    mem_resp_i = 1'b0;
    chk("refill_resp", line_resp_o, 1'b1);
    chk("refill_line", line_o, {64'hBBBB_0000_0000_0013, 64'hBBBB_0000_0000_0012,
                                64'hBBBB_0000_0000_0011, 64'hBBBB_0000_0000_0010});
    tick();

    mem_resp_i = 1'b1; mem_burst_i = 64'hEEEE_EEEE_EEEE_EEEE;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stray_rd",   mem_read_o,  1'b0);
      chk("stray_resp", line_resp_o, 1'b0);
    end
    mem_resp_i = 1'b0;
    line_read_i = 1'b1; line_addr_i = 32'h0000_4000;
    tick();
    line_read_i = 1'b0;
    mem_resp_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mem_burst_i = 64'h7000_0000_0000_0000 + 64'(k);
      tick();
    end
    mem_resp_i = 1'b0;
    chk("stray_resp_done", line_resp_o, 1'b1);
    chk("stray_beat0",     line_o[63:0], 64'h7000_0000_0000_0000);
    chk("stray_line",      line_o, {64'h7000_0000_0000_0003, 64'h7000_0000_0000_0002,
                                    64'h7000_0000_0000_0001, 64'h7000_0000_0000_0000});
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
